// File: rtl/uart_reg_dump.sv
// Purpose: snapshots PC[7:0] and x0..x7, then sends them as one 28-char ASCII hex line on UART (8N1, LSB first).
// Latency: start bit 1 cycle after an accepted trigger; the frame lasts 280*CLKS_PER_BIT cycles, then a 1-cycle done pulse.
// Backpressure: none; a trigger while busy is dropped (not queued), and a trigger in the done cycle is accepted.
module uart_reg_dump #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trigger,
   input  logic [7:0] pc,
   input  logic [7:0] x0,
   input  logic [7:0] x1,
   input  logic [7:0] x2,
   input  logic [7:0] x3,
   input  logic [7:0] x4,
   input  logic [7:0] x5,
   input  logic [7:0] x6,
   input  logic [7:0] x7,
   output logic       txd,
   output logic       busy,
   output logic       done
);

   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [4:0]        LAST_CHAR = 5'd27;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      FINISH
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [4:0]       chr_q, chr_d;
   logic             txd_q, txd_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [7:0]       snap_q [0:8];
   logic [7:0]       snap_d [0:8];

   logic             accept;
   logic             bit_end;
   logic [4:0]       byte_sel;
   logic [4:0]       pos;
   logic [7:0]       cur_byte;
   logic [3:0]       nib;
   logic [7:0]       cur_char;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Character generator: map char index c to its ASCII code from the snapshot.
   always_comb begin
      byte_sel = chr_q / 5'd3;
      pos      = chr_q - (byte_sel * 5'd3);
      cur_byte = 8'h00;
      for (int i = 0; i < 9; i++) begin
         if (byte_sel == 5'(i)) cur_byte = snap_q[i];
      end
      nib = (pos == 5'd0) ? cur_byte[7:4] : cur_byte[3:0];
      if (chr_q == 5'd26)      cur_char = 8'h0D;
      else if (chr_q == 5'd27) cur_char = 8'h0A;
      else if (pos == 5'd2)    cur_char = 8'h20;
      else                     cur_char = hex_ascii(nib);
   end

   // Next-state logic for the frame sequencer, plus the values of the registered outputs.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      chr_d   = chr_q;
      accept  = 1'b0;
      bit_end = (cnt_q == CNT_MAX);
      for (int i = 0; i < 9; i++) snap_d[i] = snap_q[i];

      case (state_q)
         IDLE, FINISH: begin
            // FINISH behaves as idle so a held trigger restarts with a one-cycle gap.
            cnt_d   = '0;
            state_d = IDLE;
            if (trigger) begin
               accept  = 1'b1;
               state_d = START;
               chr_d   = 5'd0;
               bit_d   = 3'd0;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = 3'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (chr_q == LAST_CHAR) begin
                  state_d = FINISH;
               end else begin
                  chr_d   = chr_q + 5'd1;
                  state_d = START;
               end
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      if (accept) begin
         snap_d[0] = pc;
         snap_d[1] = x0;
         snap_d[2] = x1;
         snap_d[3] = x2;
         snap_d[4] = x3;
         snap_d[5] = x4;
         snap_d[6] = x5;
         snap_d[7] = x6;
         snap_d[8] = x7;
      end

      // Outputs are decoded from the next state so they come straight out of flops.
      txd_d  = 1'b1;
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_d)
         START: begin
            txd_d  = 1'b0;
            busy_d = 1'b1;
         end
         DATA: begin
            txd_d  = cur_char[bit_d];
            busy_d = 1'b1;
         end
         STOP:    busy_d = 1'b1;
         FINISH:  done_d = 1'b1;
         default: txd_d  = 1'b1;
      endcase
   end

   // Sequencer and output registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         chr_q   <= 5'd0;
         txd_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         chr_q   <= chr_d;
         txd_q   <= txd_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Snapshot buffer; contents are irrelevant until the next accepted trigger, so no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 9; i++) snap_q[i] <= snap_d[i];
   end

   assign txd  = txd_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_uart_reg_dump.sv
// Directed bench for uart_reg_dump at CLKS_PER_BIT=4 with a sampling UART receiver.
// Log index j holds outputs sampled in cycle T+j, where T is the trigger-sampling edge.
// Expected lines are hand-written ASCII strings.
module tb_uart_reg_dump;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       trigger;
   logic [7:0] pc, x0, x1, x2, x3, x4, x5, x6, x7;
   logic       txd, busy, done;

   int n_tests = 0;
   int n_fail  = 0;

   logic txd_log  [0:2400];
   logic busy_log [0:2400];
   logic done_log [0:2400];

   string exp_a = "1C 00 05 0A FF 10 20 7E 81\r\n";
   string exp_b = "3F 12 34 56 78 9A BC DE F0\r\n";

   uart_reg_dump #(.CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .rst     (rst),
      .trigger (trigger),
      .pc      (pc),
      .x0      (x0),
      .x1      (x1),
      .x2      (x2),
      .x3      (x3),
      .x4      (x4),
      .x5      (x5),
      .x6      (x6),
      .x7      (x7),
      .txd     (txd),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic set_inputs(input logic [7:0] p, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d, input logic [7:0] e,
                             input logic [7:0] f, input logic [7:0] g, input logic [7:0] h);
      pc = p; x0 = a; x1 = b; x2 = c; x3 = d; x4 = e; x5 = f; x6 = g; x7 = h;
   endtask

   // Pulse (or hold) trigger, then log ncyc cycles; optional mid-frame input change or reset.
   task automatic run_frame(input int ncyc, input bit hold, input int mut_at, input int rst_at);
      @(negedge clk);
      trigger = 1'b1;
      for (int j = 1; j <= ncyc; j++) begin
         @(negedge clk);
         txd_log[j]  = txd;
         busy_log[j] = busy;
         done_log[j] = done;
         if (j == 1 && !hold) trigger = 1'b0;
         if (mut_at > 0 && j == mut_at) begin
            set_inputs(8'hAA, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55);
            trigger = 1'b1;
         end
         if (mut_at > 0 && j == mut_at + 1) trigger = 1'b0;
         if (rst_at > 0 && j == rst_at) rst = 1'b0;
         if (rst_at > 0 && j == rst_at + 1) rst = 1'b1;
      end
      trigger = 1'b0;
   endtask

   // Sample each data bit mid-bit, starting from the char's start-bit cycle.
   function automatic logic [7:0] rx_char(input int base);
      logic [7:0] ch;
      for (int b = 0; b < 8; b++) ch[b] = txd_log[base + CPB * (b + 1) + CPB / 2];
      return ch;
   endfunction

   task automatic check_line(input string tag, input string exp, input int off);
      int bad_frame;
      bad_frame = 0;
      for (int c = 0; c < 28; c++) begin
         check($sformatf("%s_char%0d", tag, c), rx_char(off + 1 + 10 * CPB * c), exp[c]);
         if (txd_log[off + 1 + 10 * CPB * c + CPB / 2] !== 1'b0) bad_frame++;
         if (txd_log[off + 1 + 10 * CPB * c + 9 * CPB + CPB / 2] !== 1'b1) bad_frame++;
      end
      check({tag, "_framing_errors"}, bad_frame, 0);
   endtask

   function automatic int count_ones(input int which, input int lo, input int hi);
      int n;
      n = 0;
      for (int j = lo; j <= hi; j++) begin
         if (which == 0 && busy_log[j] === 1'b1) n++;
         if (which == 1 && done_log[j] === 1'b1) n++;
      end
      return n;
   endfunction

   initial begin
      logic [9:0]  pat;
      logic [39:0] got40, exp40;
      int          n;

      // Reset with trigger held high.
      rst = 1'b0;
      trigger = 1'b1;
      set_inputs(8'h1C, 8'h00, 8'h05, 8'h0A, 8'hFF, 8'h10, 8'h20, 8'h7E, 8'h81);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("rst_txd%0d", i), txd, 1);
         check($sformatf("rst_busy%0d", i), busy, 0);
         check($sformatf("rst_done%0d", i), done, 0);
      end
      rst = 1'b1;
      trigger = 1'b0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || txd !== 1'b1 || done !== 1'b0) n++;
      end
      check("post_rst_idle_errs", n, 0);

      // Full frame, data set A.
      run_frame(1125, 1'b0, 0, 0);
      check_line("frameA", exp_a, 0);
      check("frameA_busy_cycles", count_ones(0, 1, 1125), 1120);
      check("frameA_busy_first", busy_log[1], 1);
      check("frameA_busy_last", busy_log[1120], 1);
      check("frameA_busy_after", busy_log[1121], 0);
      check("frameA_done_count", count_ones(1, 1, 1125), 1);
      check("frameA_done_at_1121", done_log[1121], 1);
      check("frameA_txd_finish", txd_log[1121], 1);

      // Bit timing of char 0 ('1' = 0x31): start, 1,0,0,0,1,1,0,0, stop.
      pat = 10'b1001100010;
      for (int i = 0; i < 40; i++) begin
         got40[i] = txd_log[1 + i];
         exp40[i] = pat[i / CPB];
      end
      check("char0_waveform", got40, exp40);
      check("char0_stop_end", txd_log[40], 1);
      check("char1_start", txd_log[41], 0);

      // Snapshot hold: inputs change and trigger pulses during char 5.
      run_frame(1125, 1'b0, 210, 0);
      check_line("snap", exp_a, 0);
      check("snap_busy_cycles", count_ones(0, 1, 1125), 1120);
      check("snap_done_count", count_ones(1, 1, 1125), 1);
      check("snap_done_at_1121", done_log[1121], 1);

      // Reset during char 10, then a clean frame with data set B.
      set_inputs(8'h3F, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0);
      run_frame(1200, 1'b0, 0, 420);
      check("midrst_busy_before", busy_log[420], 1);
      check("midrst_txd_after", txd_log[421], 1);
      check("midrst_busy_after", busy_log[421], 0);
      check("midrst_busy_tail", count_ones(0, 421, 1200), 0);
      check("midrst_done_count", count_ones(1, 1, 1200), 0);
      run_frame(1125, 1'b0, 0, 0);
      check_line("frameB", exp_b, 0);
      check("frameB_done_at_1121", done_log[1121], 1);

      // Back-to-back frames with trigger held.
      run_frame(2250, 1'b1, 0, 0);
      check("b2b_done_count", count_ones(1, 1, 2250), 2);
      check("b2b_done1", done_log[1121], 1);
      check("b2b_gap_txd", txd_log[1121], 1);
      check("b2b_gap_busy", busy_log[1121], 0);
      check("b2b_start2_txd", txd_log[1122], 0);
      check("b2b_start2_busy", busy_log[1122], 1);
      check("b2b_done2", done_log[2242], 1);
      check_line("b2b_f2", exp_b, 1121);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
